nn_scaler_sequencer: RTL and testbench

- Frame-level controller for the nearest-neighbour zoom datapath.
- On `start`, scans every destination pixel of a (LARGURA_ORIG*escala) x (ALTURA_ORIG*escala) frame in raster order.
- For each destination pixel: issues one source-ROM read, then writes the returned pixel to the destination framebuffer.
- Source addressing is incremental (sub-pixel counters), with no dividers. Sits between the ROM, the output RAM and the top-level command FSM.

---
 rtl/nn_scaler_sequencer_if.sv | 19 +
 rtl/nn_scaler_sequencer.sv | 140 ++++++++++++++
 tb/tb_nn_scaler_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/nn_scaler_sequencer_if.sv
// Source-ROM read port and destination-RAM write port of the nearest-neighbour zoom sequencer.
interface nn_scaler_sequencer_if;
    logic [14:0] rom_addr;
    logic        rom_rd;
    logic [7:0]  rom_data;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;

    modport master (
        output rom_addr, rom_rd, wr_addr, wr_data, wr_en,
        input  rom_data
    );

    modport slave (
        input  rom_addr, rom_rd, wr_addr, wr_data, wr_en,
        output rom_data
    );
endinterface

// File: rtl/nn_scaler_sequencer.sv
// Nearest-neighbour zoom frame sequencer: one ROM read per destination pixel, write-back after ROM_LAT.
// Optional feature macro NN_SCALER_CKSUM_EN adds a running 16-bit checksum of written pixels.
module nn_scaler_sequencer #(
    parameter int LARGURA_ORIG = 160,
    parameter int ALTURA_ORIG  = 120,
    parameter int ESC_MAX      = 4,
    parameter int ROM_LAT      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2:0]            escala,
    nn_scaler_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef NN_SCALER_CKSUM_EN
    ,
    output logic [15:0]           cksum
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [2:0]  e_m1, x_sub, y_sub;
    logic [9:0]  x_dest, y_dest, x_last, y_last;
    logic [14:0] x_src, row_base;
    logic [ROM_LAT-1:0] vld_p;
    logic [18:0] wr_idx;

    logic escala_ok, accept, flush, last_x, last_pix;

    assign escala_ok = (escala != 3'd0) && (int'(escala) <= ESC_MAX);
    assign accept    = (state == IDLE) && start && escala_ok;
    assign flush     = abort && ((state == RUN) || (state == DRAIN));
    assign last_x    = (x_dest == x_last);
    assign last_pix  = last_x && (y_dest == y_last);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = escala_ok ? RUN : DONE;
            RUN:   if (abort) state_nxt = IDLE;
                   else if (last_pix) state_nxt = DRAIN;
            DRAIN: if (abort) state_nxt = IDLE;
                   else if (vld_p == '0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.rom_rd   = (state == RUN);
        bus.rom_addr = (state == RUN) ? row_base + x_src : 15'd0;
        busy         = (state == RUN) || (state == DRAIN);
        done         = (state == DONE);
    end

    // Incremental source addressing: sub-pixel counters replace x/E and y/E dividers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            e_m1 <= '0; x_last <= '0; y_last <= '0;
            x_sub <= '0; y_sub <= '0; x_dest <= '0; y_dest <= '0;
            x_src <= '0; row_base <= '0;
        end else if (accept) begin
            e_m1   <= escala - 3'd1;
            x_last <= 10'(LARGURA_ORIG * int'(escala) - 1);
            y_last <= 10'(ALTURA_ORIG * int'(escala) - 1);
            x_sub <= '0; y_sub <= '0; x_dest <= '0; y_dest <= '0;
            x_src <= '0; row_base <= '0;
        end else if (state == RUN) begin
            if (last_x) begin
                x_dest <= '0;
                x_sub  <= '0;
                x_src  <= '0;
                y_dest <= y_dest + 10'd1;
                if (y_sub == e_m1) begin
                    y_sub    <= '0;
                    row_base <= row_base + 15'(LARGURA_ORIG);
                end else begin
                    y_sub <= y_sub + 3'd1;
                end
            end else begin
                x_dest <= x_dest + 10'd1;
                if (x_sub == e_m1) begin
                    x_sub <= '0;
                    x_src <= x_src + 15'd1;
                end else begin
                    x_sub <= x_sub + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)                     err <= 1'b0;
        else if (state == IDLE && start) err <= !escala_ok;
    end

    // Read-valid travels ROM_LAT stages alongside the ROM; the write stage registers data and address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p       <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            wr_idx      <= '0;
        end else begin
            if (accept) wr_idx <= '0;
            if (flush) begin
                vld_p     <= '0;
                bus.wr_en <= 1'b0;
            end else begin
                vld_p[0] <= bus.rom_rd;
                for (int i = 1; i < ROM_LAT; i++) vld_p[i] <= vld_p[i-1];
                bus.wr_en <= vld_p[ROM_LAT-1];
                if (vld_p[ROM_LAT-1]) begin
                    bus.wr_data <= bus.rom_data;
                    bus.wr_addr <= wr_idx;
                    wr_idx      <= wr_idx + 19'd1;
                end
            end
        end
    end

`ifdef NN_SCALER_CKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst)           cksum <= '0;
        else if (accept)    cksum <= '0;
        else if (bus.wr_en) cksum <= cksum + {8'd0, bus.wr_data};
    end
`endif
endmodule

// File: tb/tb_nn_scaler_sequencer.sv
// Randomized bench for nn_scaler_sequencer: a reduced 20x15 source keeps frames short while
// every write is checked against a divider-based nearest-neighbour model.
`timescale 1ns/1ps
module tb_nn_scaler_sequencer;
    localparam int L    = 20;
    localparam int A    = 15;
    localparam int EMAX = 4;
    localparam int LAT  = 2;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [2:0] escala = 3'd0;
    logic busy, done, err;
`ifdef NN_SCALER_CKSUM_EN
    logic [15:0] cksum;
`endif

    nn_scaler_sequencer_if bus();

    nn_scaler_sequencer #(
        .LARGURA_ORIG(L), .ALTURA_ORIG(A), .ESC_MAX(EMAX), .ROM_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .escala(escala),
        .bus(bus), .busy(busy), .done(done), .err(err)
`ifdef NN_SCALER_CKSUM_EN
        , .cksum(cksum)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] rom [L*A];
    logic [7:0] rpipe [LAT];
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rpipe[0] <= (bus.rom_rd && int'(bus.rom_addr) < L*A) ? rom[bus.rom_addr] : 8'h00;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bus.rom_data = rpipe[LAT-1];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    int tests = 0, fails = 0;
    int cur_e = 1, wr_n = 0, rd_n = 0, done_n = 0;
    int first_wr_cyc = -1, start_cyc = 0;
    logic [15:0] sum = 16'd0;
    logic prev_done = 1'b0;
    longint last_addr = 0, last_data = 0;
    int rd_log [L*A*16];

    // Destination index -> source index, straight from the x/E, y/E definition.
    function automatic int src_of(input int idx, input int e);
        int ee, x, y;
        ee = (e < 1) ? 1 : e;
        x = idx % (L*ee);
        y = idx / (L*ee);
        return (y / ee) * L + x / ee;
    endfunction

    function automatic logic [7:0] rom_at(input int k);
        return (k >= 0 && k < L*A) ? rom[k] : 8'h00;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (bus.rom_rd) begin
                if (rd_n < L*A*16) rd_log[rd_n] = int'(bus.rom_addr);
                check("rom_addr", longint'(bus.rom_addr), longint'(src_of(rd_n, cur_e)));
                rd_n++;
            end
            if (bus.wr_en) begin
                if (wr_n == 0) first_wr_cyc = cyc;
                check("wr_addr", longint'(bus.wr_addr), longint'(wr_n));
                check("wr_data", longint'(bus.wr_data), longint'(rom_at(src_of(wr_n, cur_e))));
                sum = sum + {8'd0, rom_at(src_of(wr_n, cur_e))};
                last_addr = longint'(bus.wr_addr);
                last_data = longint'(bus.wr_data);
                wr_n++;
            end
            if (done) begin
                check("done_width", longint'(prev_done), 0);
                done_n++;
            end
            prev_done = done;
        end
    endtask

    task automatic begin_frame(input int e);
        @(posedge clk); #1;
        cur_e = e; wr_n = 0; rd_n = 0; done_n = 0; sum = 16'd0; first_wr_cyc = -1;
        escala = 3'(e);
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int e, input bit bad);
        int n, expw;
        expw = bad ? 0 : L*e*A*e;
        n = 0;
        while (done_n == 0 && n < expw + 100) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", longint'(done_n), 1);
        check("err", longint'(err), longint'(bad));
        @(negedge clk);
        check("writes", longint'(wr_n), longint'(expw));
        check("reads", longint'(rd_n), longint'(expw));
        check("busy_after_done", longint'(busy), 0);
        check("done_after_done", longint'(done), 0);
`ifdef NN_SCALER_CKSUM_EN
        if (!bad) check("cksum", longint'(cksum), longint'(sum));
`endif
    endtask

    task automatic run_frame(input int e, input bit bad);
        begin_frame(e);
        wait_end(e, bad);
    endtask

    task automatic randomize_rom();
        for (int k = 0; k < L*A; k++) rom[k] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int w, r, n;
        fork
            monitor();
        join_none

        for (int k = 0; k < L*A; k++) rom[k] = 8'(k % 256);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rom_rd", longint'(bus.rom_rd), 0);
        check("rst_rom_addr", longint'(bus.rom_addr), 0);
        check("rst_wr_en", longint'(bus.wr_en), 0);
        check("rst_wr_addr", longint'(bus.wr_addr), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_err", longint'(err), 0);
        @(posedge clk); #1 rst = 1'b1;

        // Hand-computed pins for the model (row of 40 at E=2).
        check("model_x1y1", longint'(src_of(41, 2)), 0);
        check("model_x3y1", longint'(src_of(43, 2)), 1);
        check("model_x0y2", longint'(src_of(80, 2)), 20);
        check("model_last_e4", longint'(src_of(4799, 4)), 299);

        // E=1, ROM[k] = k mod 256
        run_frame(1, 1'b0);
        check("first_wr_latency", longint'(first_wr_cyc - start_cyc), longint'(LAT + 2));
        check("e1_last_addr", last_addr, 299);
        check("e1_last_data", last_data, 299 % 256);

        randomize_rom();
        run_frame(2, 1'b0);
        check("e2_rd_addr_41", longint'(rd_log[41]), 0);
        check("e2_rd_addr_43", longint'(rd_log[43]), 1);
        check("e2_rd_addr_80", longint'(rd_log[80]), 20);

        run_frame(4, 1'b0);
        check("e4_last_addr", last_addr, 4799);
        check("e4_last_data", last_data, longint'(rom[L*A-1]));

        run_frame(0, 1'b1);
        run_frame(5, 1'b1);
        run_frame(1, 1'b0);

        // Abort after 500 writes at E=3
        begin_frame(3);
        n = 0;
        while (wr_n < 500 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        check("abort_reached_500", longint'(wr_n >= 500), 1);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        w = wr_n;
        r = rd_n;
        repeat (10) @(negedge clk);
        check("abort_no_writes", longint'(wr_n), longint'(w));
        check("abort_no_reads", longint'(rd_n), longint'(r));
        check("abort_busy", longint'(busy), 0);
        check("abort_no_done", longint'(done_n), 0);

        // Mid-frame start must be ignored
        begin_frame(2);
        repeat (100) @(posedge clk);
        #1 escala = 3'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_end(2, 1'b0);

        // One-cycle reset mid-frame
        begin_frame(2);
        repeat (300) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rom_rd", longint'(bus.rom_rd), 0);
        check("mid_rst_rom_addr", longint'(bus.rom_addr), 0);
        check("mid_rst_wr_en", longint'(bus.wr_en), 0);
        check("mid_rst_wr_addr", longint'(bus.wr_addr), 0);
        check("mid_rst_wr_data", longint'(bus.wr_data), 0);
        check("mid_rst_busy", longint'(busy), 0);
        check("mid_rst_done", longint'(done), 0);
        check("mid_rst_err", longint'(err), 0);
`ifdef NN_SCALER_CKSUM_EN
        check("mid_rst_cksum", longint'(cksum), 0);
`endif
        run_frame(2, 1'b0);

        for (int i = 0; i < 2; i++) begin
            randomize_rom();
            run_frame(int'($urandom_range(1, EMAX)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
